bounded_updown_counter: RTL and testbench
=========================================

BOUNDED_UPDOWN_COUNTER -- requirements
Module: bounded_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, 8, signed width of count, step, load and bounds (min 4).
REQ-002 SHALL have parameter EVT_W, 8, width of out-of-range event counter.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ld  input  1  load request.
REQ-006 SHALL have port load_val  input  WIDTH  signed value loaded on ld.
REQ-007 SHALL have port up  input  1  add step request.
REQ-008 SHALL have port dn  input  1  subtract step request.
REQ-009 SHALL have port step  input  WIDTH  signed step magnitude.
REQ-010 SHALL have port lo  input  WIDTH  signed lower bound, inclusive.
REQ-011 SHALL have port hi  input  WIDTH  signed upper bound, inclusive.
REQ-012 SHALL have port mode  input  2  out-of-range policy: 0 HOLD, 1 SAT, 2 WRAP, 3 reserved (behaves as HOLD).
REQ-013 SHALL have port q  output  WIDTH  signed registered count.
REQ-014 SHALL have port ovf  output  1  one-cycle pulse: last step exceeded hi.
REQ-015 SHALL have port unf  output  1  one-cycle pulse: last step went below lo.
REQ-016 SHALL have port bnd_err  output  1  registered; high while lo > hi.
REQ-017 SHALL have port evt_clr  input  1  clears event counter (present only with macro, REQ-033).
REQ-018 SHALL have port evt_cnt  output  EVT_W  saturating count of ovf/unf pulses (present only with macro).

Function
- REQ-019 Priority per cycle: rst > ld > up > dn; up and dn together act as up only.
- REQ-020 ld: q <= load_val clamped to [lo,hi]; no ovf/unf pulse.
- REQ-021 Candidate r = q + step (up) or q - step (dn), computed signed in WIDTH+2 bits; no intermediate truncation.
- REQ-022 r within [lo,hi]: q <= r, ovf=unf=0.
- REQ-023 r > hi: ovf=1 next cycle; HOLD q unchanged; SAT q <= hi; WRAP q <= lo.
- REQ-024 r < lo: unf=1 next cycle; HOLD q unchanged; SAT q <= lo; WRAP q <= hi.
- REQ-025 Idle cycle (no ld/up/dn): q holds; ovf, unf deassert.
- REQ-026 lo > hi: bnd_err=1 next cycle; up/dn ignored, q held, no pulses; ld still loads load_val unclamped.
- REQ-027 step is signed; a negative step with up decrements; rules REQ-022..024 apply unchanged.
- REQ-028 Latency: q, ovf, unf, bnd_err valid one cycle after the sampling edge; no combinational input-to-output path.
- REQ-029 mode, lo, hi sampled every cycle; changing them does not alter q until the next step or load.

Reset
- REQ-030 On rst: q=0, ovf=0, unf=0, bnd_err=0, evt_cnt=0, regardless of other inputs.
- REQ-031 rst asserted during a step cancels the step; no pulse produced.

Configuration
- REQ-032 Macro BOUNDED_UPDOWN_COUNTER_EVT_EN compiles event counting in or out.
- REQ-033 Defined: evt_clr/evt_cnt exist; evt_cnt increments on each ovf or unf pulse, saturates at 2^EVT_W-1, evt_clr zeroes it, clear wins over a simultaneous increment.
- REQ-034 Undefined: evt_clr/evt_cnt absent, no event-counter logic; all other behaviour identical.

Structure
- REQ-035 Package bounded_updown_counter_pkg holds mode encodings (MODE_HOLD, MODE_SAT, MODE_WRAP) and a mode typedef.
- REQ-036 Sub-module bud_next_calc (combinational) computes the extended candidate, range compare, and next q/ovf/unf; the top holds registers and the event counter.

Verification (WIDTH=8, lo=-128, hi=127 unless stated)
- REQ-037 rst with q=55 -> next cycle q=0, ovf=unf=0, evt_cnt=0.
- REQ-038 HOLD, q=120, step=10, up -> q stays 120, ovf pulses one cycle; SAT same -> q=127; WRAP same -> q=-128.
- REQ-039 lo=-10, hi=10, q=-5, step=8, dn, mode SAT -> q=-10, unf=1; ld load_val=50 -> q=10, no pulse.
- REQ-040 up and dn together, q=0, step=3 -> q=3; step=-3 with up -> q=-3.
- REQ-041 lo=5, hi=-5, up -> bnd_err=1, q unchanged; restore lo<hi -> bnd_err=0 next cycle.
- REQ-042 With macro, EVT_W=2: four overflow steps -> evt_cnt 1,2,3,3; evt_clr with overflow in the same cycle -> evt_cnt=0.

Source files
------------

// File: rtl/bounded_updown_counter_pkg.sv
// Shared definitions for the bounded up/down counter: the out-of-range policy
// encodings and a helper that folds the reserved encoding onto HOLD.
package bounded_updown_counter_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_SAT  = 2'd1,
        MODE_WRAP = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    // The reserved encoding is treated exactly like HOLD.
    function automatic mode_t decode_mode(input logic [1:0] raw);
        mode_t m;
        case (raw)
            2'd1:    m = MODE_SAT;
            2'd2:    m = MODE_WRAP;
            default: m = MODE_HOLD;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/bud_next_calc.sv
// Combinational next-state logic for the bounded up/down counter.
// Computes the step candidate two bits wider than the count so that neither
// the add nor the subtract can overflow, compares it against the bounds and
// applies the selected out-of-range policy.
module bud_next_calc
    import bounded_updown_counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0] q,
    input  logic                    ld,
    input  logic signed [WIDTH-1:0] load_val,
    input  logic                    up,
    input  logic                    dn,
    input  logic signed [WIDTH-1:0] step,
    input  logic signed [WIDTH-1:0] lo,
    input  logic signed [WIDTH-1:0] hi,
    input  logic [1:0]              mode,
    output logic signed [WIDTH-1:0] q_next,
    output logic                    ovf_next,
    output logic                    unf_next,
    output logic                    bnd_err_next
);

    localparam int XW = WIDTH + 2;

    logic signed [XW-1:0] q_x_s;
    logic signed [XW-1:0] step_x_s;
    logic signed [XW-1:0] lo_x_s;
    logic signed [XW-1:0] hi_x_s;
    logic signed [XW-1:0] ld_x_s;
    logic signed [XW-1:0] cand_x_s;
    logic                 bnd_bad_s;
    mode_t                mode_s;

    // Sign-extend all operands and form the step candidate without truncation.
    always_comb begin
        q_x_s     = {{2{q[WIDTH-1]}}, q};
        step_x_s  = {{2{step[WIDTH-1]}}, step};
        lo_x_s    = {{2{lo[WIDTH-1]}}, lo};
        hi_x_s    = {{2{hi[WIDTH-1]}}, hi};
        ld_x_s    = {{2{load_val[WIDTH-1]}}, load_val};
        bnd_bad_s = (lo_x_s > hi_x_s);
        mode_s    = decode_mode(mode);
        if (up) begin
            cand_x_s = q_x_s + step_x_s;
        end else begin
            cand_x_s = q_x_s - step_x_s;
        end
    end

    // Select the next count and event pulses: load, then step, else hold.
    always_comb begin
        q_next       = q;
        ovf_next     = 1'b0;
        unf_next     = 1'b0;
        bnd_err_next = bnd_bad_s;
        if (ld) begin
            if (bnd_bad_s) begin
                q_next = load_val;
            end else if (ld_x_s > hi_x_s) begin
                q_next = hi;
            end else if (ld_x_s < lo_x_s) begin
                q_next = lo;
            end else begin
                q_next = load_val;
            end
        end else if ((up || dn) && !bnd_bad_s) begin
            if (cand_x_s > hi_x_s) begin
                ovf_next = 1'b1;
                case (mode_s)
                    MODE_SAT:  q_next = hi;
                    MODE_WRAP: q_next = lo;
                    default:   q_next = q;
                endcase
            end else if (cand_x_s < lo_x_s) begin
                unf_next = 1'b1;
                case (mode_s)
                    MODE_SAT:  q_next = lo;
                    MODE_WRAP: q_next = hi;
                    default:   q_next = q;
                endcase
            end else begin
                q_next = cand_x_s[WIDTH-1:0];
            end
        end else begin
            q_next = q;
        end
    end

endmodule

// File: rtl/bounded_updown_counter.sv
// Bounded signed up/down counter with HOLD / SAT / WRAP out-of-range policy.
// All outputs are registered; next-state logic lives in bud_next_calc.
// Optional event counter enabled by defining BOUNDED_UPDOWN_COUNTER_EVT_EN.
module bounded_updown_counter
    import bounded_updown_counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int EVT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld,
    input  logic signed [WIDTH-1:0] load_val,
    input  logic                    up,
    input  logic                    dn,
    input  logic signed [WIDTH-1:0] step,
    input  logic signed [WIDTH-1:0] lo,
    input  logic signed [WIDTH-1:0] hi,
    input  logic [1:0]              mode,
    output logic signed [WIDTH-1:0] q,
    output logic                    ovf,
    output logic                    unf,
    output logic                    bnd_err
`ifdef BOUNDED_UPDOWN_COUNTER_EVT_EN
    ,
    input  logic                    evt_clr,
    output logic [EVT_W-1:0]        evt_cnt
`endif
);

    logic signed [WIDTH-1:0] q_r;
    logic                    ovf_r;
    logic                    unf_r;
    logic                    bnd_err_r;
    logic signed [WIDTH-1:0] q_next_s;
    logic                    ovf_next_s;
    logic                    unf_next_s;
    logic                    bnd_err_next_s;

    bud_next_calc #(
        .WIDTH (WIDTH)
    ) u_next (
        .q            (q_r),
        .ld           (ld),
        .load_val     (load_val),
        .up           (up),
        .dn           (dn),
        .step         (step),
        .lo           (lo),
        .hi           (hi),
        .mode         (mode),
        .q_next       (q_next_s),
        .ovf_next     (ovf_next_s),
        .unf_next     (unf_next_s),
        .bnd_err_next (bnd_err_next_s)
    );

    // Count, pulse and bound-error registers; reset cancels any pending step.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r       <= '0;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
            bnd_err_r <= 1'b0;
        end else begin
            q_r       <= q_next_s;
            ovf_r     <= ovf_next_s;
            unf_r     <= unf_next_s;
            bnd_err_r <= bnd_err_next_s;
        end
    end

    assign q       = q_r;
    assign ovf     = ovf_r;
    assign unf     = unf_r;
    assign bnd_err = bnd_err_r;

`ifdef BOUNDED_UPDOWN_COUNTER_EVT_EN
    localparam logic [EVT_W-1:0] EVT_MAX = {EVT_W{1'b1}};

    logic [EVT_W-1:0] evt_cnt_r;

    // Saturating event counter, updated in the same cycle the pulse registers,
    // so evt_cnt moves together with ovf/unf; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_cnt_r <= '0;
        end else if (evt_clr) begin
            evt_cnt_r <= '0;
        end else if ((ovf_next_s || unf_next_s) && (evt_cnt_r != EVT_MAX)) begin
            evt_cnt_r <= evt_cnt_r + EVT_W'(1);
        end else begin
            evt_cnt_r <= evt_cnt_r;
        end
    end

    assign evt_cnt = evt_cnt_r;
`endif

endmodule

// File: tb/tb_bounded_updown_counter.sv
// Self-checking bench for bounded_updown_counter: directed scenarios followed
// by randomized stimulus against an integer-arithmetic reference model.
module tb_bounded_updown_counter;

    localparam int WIDTH   = 8;
    localparam int EVT_W   = 2;
    localparam int EVT_MAX = (1 << EVT_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    ld = 1'b0;
    logic signed [WIDTH-1:0] load_val = '0;
    logic                    up = 1'b0;
    logic                    dn = 1'b0;
    logic signed [WIDTH-1:0] step = '0;
    logic signed [WIDTH-1:0] lo = '0;
    logic signed [WIDTH-1:0] hi = '0;
    logic [1:0]              mode = 2'd0;
    logic signed [WIDTH-1:0] q;
    logic                    ovf;
    logic                    unf;
    logic                    bnd_err;
    logic                    evt_clr = 1'b0;
    logic [EVT_W-1:0]        evt_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state (plain integers)
    int m_q   = 0;
    int m_ovf = 0;
    int m_unf = 0;
    int m_bnd = 0;
    int m_evt = 0;

    bounded_updown_counter #(
        .WIDTH (WIDTH),
        .EVT_W (EVT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .load_val (load_val),
        .up       (up),
        .dn       (dn),
        .step     (step),
        .lo       (lo),
        .hi       (hi),
        .mode     (mode),
        .q        (q),
        .ovf      (ovf),
        .unf      (unf),
        .bnd_err  (bnd_err)
`ifdef BOUNDED_UPDOWN_COUNTER_EVT_EN
        ,
        .evt_clr  (evt_clr),
        .evt_cnt  (evt_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference behaviour from the counter's rules, in unbounded integers.
    task automatic model_step(input bit r, input bit l, input int lv, input bit u, input bit d,
                              input int st, input int l0, input int h0, input int md, input bit clr);
        int rr;
        int pulse;
        if (r) begin
            m_q = 0; m_ovf = 0; m_unf = 0; m_bnd = 0; m_evt = 0;
            return;
        end
        m_ovf = 0;
        m_unf = 0;
        m_bnd = (l0 > h0) ? 1 : 0;
        if (l) begin
            if (m_bnd != 0)    m_q = lv;
            else if (lv > h0)  m_q = h0;
            else if (lv < l0)  m_q = l0;
            else               m_q = lv;
        end else if ((u || d) && m_bnd == 0) begin
            rr = u ? (m_q + st) : (m_q - st);
            if (rr > h0) begin
                m_ovf = 1;
                if (md == 1)      m_q = h0;
                else if (md == 2) m_q = l0;
            end else if (rr < l0) begin
                m_unf = 1;
                if (md == 1)      m_q = l0;
                else if (md == 2) m_q = h0;
            end else begin
                m_q = rr;
            end
        end
        pulse = m_ovf | m_unf;
        if (clr)                           m_evt = 0;
        else if (pulse != 0 && m_evt < EVT_MAX) m_evt = m_evt + 1;
    endtask

    // Apply one cycle of inputs, clock it, advance the model and compare.
    task automatic cyc(input bit r, input bit l, input int lv, input bit u, input bit d,
                       input int st, input int l0, input int h0, input int md, input bit clr);
        rst      = r;
        ld       = l;
        load_val = lv[WIDTH-1:0];
        up       = u;
        dn       = d;
        step     = st[WIDTH-1:0];
        lo       = l0[WIDTH-1:0];
        hi       = h0[WIDTH-1:0];
        mode     = md[1:0];
        evt_clr  = clr;
        @(posedge clk);
        #1;
        model_step(r, l, lv, u, d, st, l0, h0, md, clr);
        check("q", int'(q), m_q);
        check("ovf", int'(ovf), m_ovf);
        check("unf", int'(unf), m_unf);
        check("bnd_err", int'(bnd_err), m_bnd);
`ifdef BOUNDED_UPDOWN_COUNTER_EVT_EN
        check("evt_cnt", int'(evt_cnt), m_evt);
`endif
    endtask

    task automatic idle(input int l0, input int h0, input int md);
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, l0, h0, md, 1'b0);
    endtask

    task automatic load(input int v, input int l0, input int h0);
        cyc(1'b0, 1'b1, v, 1'b0, 1'b0, 0, l0, h0, 0, 1'b0);
    endtask

    initial begin
        int a, b, t, md;
        bit r, l, u, d, c;

        // Reset state, then reset while q=55
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, -128, 127, 0, 1'b0);
        check("rst_q", int'(q), 0);
        load(55, -128, 127);
        check("ld55", int'(q), 55);
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 100, -128, 127, 0, 1'b0);
        check("rst_q55", int'(q), 0);
        check("rst_ovf", int'(ovf), 0);

        // Overflow in HOLD, SAT and WRAP
        load(120, -128, 127);
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b0, 10, -128, 127, 0, 1'b0);
        check("hold_q", int'(q), 120);
        check("hold_ovf", int'(ovf), 1);
        idle(-128, 127, 0);
        check("hold_ovf_drop", int'(ovf), 0);
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b0, 10, -128, 127, 1, 1'b0);
        check("sat_q", int'(q), 127);
        load(120, -128, 127);
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b0, 10, -128, 127, 2, 1'b0);
        check("wrap_q", int'(q), -128);

        // Underflow with SAT on a narrow window, then clamped load
        load(-5, -10, 10);
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b1, 8, -10, 10, 1, 1'b0);
        check("sat_unf_q", int'(q), -10);
        check("sat_unf", int'(unf), 1);
        load(50, -10, 10);
        check("ld_clamp", int'(q), 10);
        check("ld_nopulse", int'(ovf | unf), 0);

        // up+dn acts as up; negative step with up decrements
        load(0, -128, 127);
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b1, 3, -128, 127, 0, 1'b0);
        check("updn", int'(q), 3);
        load(0, -128, 127);
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b0, -3, -128, 127, 0, 1'b0);
        check("negstep", int'(q), -3);

        // Inverted bounds
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b0, 1, 5, -5, 0, 1'b0);
        check("bnd_err_on", int'(bnd_err), 1);
        check("bnd_hold", int'(q), -3);
        load(100, 5, -5);
        check("bnd_ld_raw", int'(q), 100);
        idle(-128, 127, 0);
        check("bnd_err_off", int'(bnd_err), 0);

`ifdef BOUNDED_UPDOWN_COUNTER_EVT_EN
        // Event counter saturation and clear-wins
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, -128, 127, 0, 1'b1);
        load(120, -128, 127);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 0, 1'b1, 1'b0, 10, -128, 127, 0, 1'b0);
            check("evt_seq", int'(evt_cnt), (i < 3) ? i + 1 : 3);
        end
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b0, 10, -128, 127, 0, 1'b1);
        check("evt_clr_wins", int'(evt_cnt), 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            a  = $urandom_range(0, 255) - 128;
            b  = $urandom_range(0, 255) - 128;
            if ($urandom_range(0, 9) != 0 && a > b) begin
                t = a; a = b; b = t;
            end
            md = $urandom_range(0, 3);
            r  = ($urandom_range(0, 49) == 0);
            l  = ($urandom_range(0, 9) == 0);
            u  = ($urandom_range(0, 9) < 4);
            d  = ($urandom_range(0, 9) < 4);
            c  = ($urandom_range(0, 19) == 0);
            t  = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 255) - 128)
                                              : ($urandom_range(0, 20) - 10);
            cyc(r, l, $urandom_range(0, 255) - 128, u, d, t, a, b, md, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
